thunderbolt_time_sync_ctrl: RTL and testbench

Sequencer between the Thunderbolt packet decoder and the local time-of-day counter. Captures each valid timing packet, range-checks it and computes packet time + 1 s. Issues a single-cycle load to the time counter on the next PPS rising edge. Tracks lock and packet-loss timeout for the register bank.

---
 rtl/thunderbolt_time_sync_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_thunderbolt_time_sync_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thunderbolt_time_sync_ctrl.sv
// Thunderbolt packet to time-of-day load sequencer with PPS alignment.
// Optional: define THUNDER_LEAPSEC_EN to accept seconds==60.
module thunderbolt_time_sync_ctrl #(
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int LOCK_COUNT     = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_thunder_packet_dv,
  input  logic [7:0]  i_thunder_year_h,
  input  logic [7:0]  i_thunder_year_l,
  input  logic [7:0]  i_thunder_month,
  input  logic [7:0]  i_thunder_day,
  input  logic [7:0]  i_thunder_hour,
  input  logic [7:0]  i_thunder_minutes,
  input  logic [7:0]  i_thunder_seconds,
  input  logic        i_pps,
  output logic        o_load,
  output logic [15:0] o_year,
  output logic [7:0]  o_month,
  output logic [7:0]  o_day,
  output logic [7:0]  o_hour,
  output logic [7:0]  o_minutes,
  output logic [7:0]  o_seconds,
  output logic        o_locked,
  output logic        o_timeout,
  output logic [7:0]  o_err_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_COUNT);

`ifdef THUNDER_LEAPSEC_EN
  localparam logic [7:0] SEC_MAX = 8'd60;
`else
  localparam logic [7:0] SEC_MAX = 8'd59;
`endif

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PKT,
    INCR,
    WAIT_PPS,
    LOAD
  } state_t;

  function automatic logic [7:0] dim(
    input logic       leap,
    input logic [7:0] mon
  );
    case (mon)
      8'd2:    dim = leap ? 8'd29 : 8'd28;
      8'd4,
      8'd6,
      8'd9,
      8'd11:   dim = 8'd30;
      default: dim = 8'd31;
    endcase
  endfunction

  state_t state, state_nx;

  logic          pps_meta, pps_sync, pps_prev;
  logic          pps_edge;
  logic [15:0]   pkt_year;
  logic          pkt_ok, dv_ok, dv_bad;
  logic [TW-1:0] to_cnt;
  logic          to_hit, to_fire;
  logic [LW-1:0] lock_cnt, lock_inc;
  logic          cap_go, load_go;

  logic [15:0] cap_year, nxt_year, inc_year;
  logic [7:0]  cap_mon, cap_day, cap_hour, cap_min, cap_sec;
  logic [7:0]  nxt_mon, nxt_day, nxt_hour, nxt_min, nxt_sec;
  logic [7:0]  inc_mon, inc_day, inc_hour, inc_min, inc_sec;

  assign pps_edge = pps_sync & ~pps_prev;
  assign pkt_year = {i_thunder_year_h, i_thunder_year_l};

  // Range check of the presented packet fields
  always_comb begin
    pkt_ok = (pkt_year >= 16'd2000) && (pkt_year <= 16'd2099) &&
             (i_thunder_month >= 8'd1) && (i_thunder_month <= 8'd12) &&
             (i_thunder_day >= 8'd1) &&
             (i_thunder_day <= dim(pkt_year[1:0] == 2'b00,
                                   i_thunder_month)) &&
             (i_thunder_hour <= 8'd23) &&
             (i_thunder_minutes <= 8'd59) &&
             (i_thunder_seconds <= SEC_MAX);
  end

  assign dv_ok   = i_thunder_packet_dv & pkt_ok;
  assign dv_bad  = i_thunder_packet_dv & ~pkt_ok;
  assign to_hit  = (to_cnt == TO_LAST);
  assign to_fire = to_hit && (state != IDLE) && !dv_ok && i_enable;
  assign cap_go  = (state_nx == INCR);
  assign load_go = (state_nx == LOAD);
  assign lock_inc = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;

  // Two-flop PPS synchronizer plus previous sample for edge detect
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pps_meta <= 1'b0;
      pps_sync <= 1'b0;
      pps_prev <= 1'b0;
    end else begin
      pps_meta <= i_pps;
      pps_sync <= pps_meta;
      pps_prev <= pps_sync;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state; disable beats timeout, timeout beats normal flow
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (i_enable) state_nx = WAIT_PKT;
      WAIT_PKT: if (dv_ok) state_nx = INCR;
      INCR:     state_nx = WAIT_PPS;
      WAIT_PPS: begin
        if (pps_edge)   state_nx = LOAD;
        else if (dv_ok) state_nx = INCR;
      end
      LOAD:     state_nx = WAIT_PKT;
      default:  state_nx = IDLE;
    endcase
    if (to_fire)   state_nx = WAIT_PKT;
    if (!i_enable) state_nx = IDLE;
  end

  // Load strobe is the LOAD state itself, so reset drops it at once
  always_comb begin
    o_load = (state == LOAD);
  end

  // Captured time plus one second, with the full calendar carry chain
  always_comb begin
    inc_year = cap_year;
    inc_mon  = cap_mon;
    inc_day  = cap_day;
    inc_hour = cap_hour;
    inc_min  = cap_min;
    inc_sec  = cap_sec + 8'd1;
    if (cap_sec >= 8'd59) begin
      inc_sec = 8'd0;
      inc_min = cap_min + 8'd1;
      if (cap_min == 8'd59) begin
        inc_min  = 8'd0;
        inc_hour = cap_hour + 8'd1;
        if (cap_hour == 8'd23) begin
          inc_hour = 8'd0;
          inc_day  = cap_day + 8'd1;
          if (cap_day == dim(cap_year[1:0] == 2'b00, cap_mon)) begin
            inc_day = 8'd1;
            inc_mon = cap_mon + 8'd1;
            if (cap_mon == 8'd12) begin
              inc_mon  = 8'd1;
              inc_year = cap_year + 16'd1;
            end
          end
        end
      end
    end
  end

  // Packet capture and registered increment result
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cap_year <= '0; cap_mon <= '0; cap_day <= '0;
      cap_hour <= '0; cap_min <= '0; cap_sec <= '0;
      nxt_year <= '0; nxt_mon <= '0; nxt_day <= '0;
      nxt_hour <= '0; nxt_min <= '0; nxt_sec <= '0;
    end else if (!i_enable) begin
      cap_year <= '0; cap_mon <= '0; cap_day <= '0;
      cap_hour <= '0; cap_min <= '0; cap_sec <= '0;
      nxt_year <= '0; nxt_mon <= '0; nxt_day <= '0;
      nxt_hour <= '0; nxt_min <= '0; nxt_sec <= '0;
    end else if (cap_go) begin
      cap_year <= pkt_year;
      cap_mon  <= i_thunder_month;
      cap_day  <= i_thunder_day;
      cap_hour <= i_thunder_hour;
      cap_min  <= i_thunder_minutes;
      cap_sec  <= i_thunder_seconds;
    end else if (state == INCR) begin
      nxt_year <= inc_year; nxt_mon <= inc_mon; nxt_day <= inc_day;
      nxt_hour <= inc_hour; nxt_min <= inc_min; nxt_sec <= inc_sec;
    end
  end

  // Time outputs change only as LOAD is entered and hold otherwise
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_year <= '0; o_month <= '0; o_day <= '0;
      o_hour <= '0; o_minutes <= '0; o_seconds <= '0;
    end else if (load_go) begin
      o_year    <= nxt_year;
      o_month   <= nxt_mon;
      o_day     <= nxt_day;
      o_hour    <= nxt_hour;
      o_minutes <= nxt_min;
      o_seconds <= nxt_sec;
    end
  end

  // Packet-loss counter saturates at its last value and holds there
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      to_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (!i_enable || dv_ok)
        to_cnt <= '0;
      else if (state != IDLE && !to_hit)
        to_cnt <= to_cnt + 1'b1;
      if (dv_ok)        o_timeout <= 1'b0;
      else if (to_fire) o_timeout <= 1'b1;
    end
  end

  // Lock tracking over consecutive successful loads
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      lock_cnt <= '0;
      o_locked <= 1'b0;
    end else if (!i_enable || to_fire ||
                 (state == WAIT_PKT && dv_bad)) begin
      lock_cnt <= '0;
      o_locked <= 1'b0;
    end else if (load_go) begin
      lock_cnt <= lock_inc;
      o_locked <= (lock_inc == LOCK_MAX);
    end
  end

  // Saturating count of rejected packets while waiting for data
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      o_err_cnt <= '0;
    else if (dv_bad && (state == WAIT_PKT || state == WAIT_PPS) &&
             o_err_cnt != 8'hff)
      o_err_cnt <= o_err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_thunderbolt_time_sync_ctrl.sv
// Bench for thunderbolt_time_sync_ctrl: directed cases plus random rounds
// checked against a seconds-since-epoch calendar model.
module tb_thunderbolt_time_sync_ctrl;

  localparam int TO = 1000;
  localparam int LC = 3;

  typedef struct packed {
    logic [15:0] y;
    logic [7:0]  mo, d, h, mi, s;
  } tod_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  yh = '0, yl = '0, mon = '0, day = '0;
  logic [7:0]  hour = '0, mins = '0, secs = '0;
  logic        pps = 1'b0;
  logic        load;
  logic [15:0] o_year;
  logic [7:0]  o_month, o_day, o_hour, o_minutes, o_seconds;
  logic        locked, timeout;
  logic [7:0]  err_cnt;

  int   n_chk = 0;
  int   n_pass = 0;
  int   err_m = 0;
  int   lock_m = 0;
  tod_t last;

  always #5 clk = ~clk;

  thunderbolt_time_sync_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .LOCK_COUNT(LC)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_enable(enable),
    .i_thunder_packet_dv(dv),
    .i_thunder_year_h(yh),
    .i_thunder_year_l(yl),
    .i_thunder_month(mon),
    .i_thunder_day(day),
    .i_thunder_hour(hour),
    .i_thunder_minutes(mins),
    .i_thunder_seconds(secs),
    .i_pps(pps),
    .o_load(load),
    .o_year(o_year),
    .o_month(o_month),
    .o_day(o_day),
    .o_hour(o_hour),
    .o_minutes(o_minutes),
    .o_seconds(o_seconds),
    .o_locked(locked),
    .o_timeout(timeout),
    .o_err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic tod_t mk(int y, int mo, int d, int h, int mi, int s);
    tod_t t;
    t.y = 16'(y); t.mo = 8'(mo); t.d = 8'(d);
    t.h = 8'(h); t.mi = 8'(mi); t.s = 8'(s);
    return t;
  endfunction

  function automatic int ylen(int y);
    return (y % 4 == 0) ? 366 : 365;
  endfunction

  function automatic int dim(int y, int m);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic longint to_secs(tod_t t);
    longint days = 0;
    for (int yy = 2000; yy < int'(t.y); yy++) days += ylen(yy);
    for (int m = 1; m < int'(t.mo); m++) days += dim(int'(t.y), m);
    days += longint'(t.d) - 1;
    return days * 86400 + longint'(t.h) * 3600 +
           longint'(t.mi) * 60 + longint'(t.s);
  endfunction

  function automatic tod_t from_secs(longint x);
    longint days = x / 86400;
    longint rem = x % 86400;
    int y = 2000;
    int m = 1;
    while (days >= ylen(y)) begin days -= ylen(y); y++; end
    while (days >= dim(y, m)) begin days -= dim(y, m); m++; end
    return mk(y, m, int'(days) + 1, int'(rem / 3600),
              int'((rem / 60) % 60), int'(rem % 60));
  endfunction

  function automatic tod_t plus1(tod_t t);
    return from_secs(to_secs(t) + 1);
  endfunction

  function automatic tod_t rand_valid();
    tod_t t;
    t.y  = 16'(2000 + $urandom_range(0, 99));
    t.mo = 8'($urandom_range(1, 12));
    t.d  = 8'($urandom_range(1, dim(int'(t.y), int'(t.mo))));
    t.h  = 8'($urandom_range(0, 23));
    t.mi = 8'($urandom_range(0, 59));
    t.s  = 8'($urandom_range(0, 59));
    if ($urandom_range(0, 2) == 0) begin
      t.s = 8'd59; t.mi = 8'd59; t.h = 8'd23;
      if ($urandom_range(0, 1) == 0)
        t.d = 8'(dim(int'(t.y), int'(t.mo)));
    end
    return t;
  endfunction

  function automatic tod_t rand_bad();
    tod_t t = rand_valid();
    int lim = dim(int'(t.y), int'(t.mo));
    case ($urandom_range(0, 5))
      0: t.y = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 1999))
                                           : 16'($urandom_range(2100, 65535));
      1: t.mo = ($urandom_range(0, 1) == 1) ? 8'd0
                                            : 8'($urandom_range(13, 255));
      2: t.d = ($urandom_range(0, 1) == 1) ? 8'd0
                                           : 8'($urandom_range(lim + 1, 255));
      3: t.h = 8'($urandom_range(24, 255));
      4: t.mi = 8'($urandom_range(60, 255));
      default: t.s = 8'($urandom_range(61, 255));
    endcase
    return t;
  endfunction

  task automatic drive(input tod_t t);
    yh = t.y[15:8]; yl = t.y[7:0]; mon = t.mo; day = t.d;
    hour = t.h; mins = t.mi; secs = t.s;
  endtask

  task automatic send(input tod_t t);
    @(negedge clk);
    drive(t);
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic chk_tod(input string tag, input tod_t exp);
    chk(tag, {o_year, o_month, o_day, o_hour, o_minutes, o_seconds}, exp);
  endtask

  // Raise PPS and require o_load exactly on the third clock, not before
  task automatic pps_expect(input string tag, input logic exp_load,
                            input tod_t exp);
    @(negedge clk);
    pps = 1'b1;
    @(negedge clk);
    chk({tag, "_ld1"}, load, 0);
    @(negedge clk);
    chk({tag, "_ld2"}, load, 0);
    @(negedge clk);
    chk({tag, "_ld3"}, load, exp_load);
    if (exp_load) begin
      lock_m = (lock_m < LC) ? lock_m + 1 : LC;
      last = exp;
      chk_tod({tag, "_tod"}, exp);
      chk({tag, "_lock"}, locked, lock_m == LC);
    end
    pps = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_ldoff"}, load, 0);
  endtask

  tod_t a, b, t;

  initial begin
    enable = 1'b1;
    last = '0;
    @(negedge clk);
    chk("rst_load", load, 0);
    chk_tod("rst_tod", '0);
    chk("rst_lock", locked, 0);
    chk("rst_to", timeout, 0);
    chk("rst_err", err_cnt, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    send(mk(2023, 6, 15, 12, 34, 56));
    repeat (900) @(negedge clk);
    pps_expect("basic", 1'b1, mk(2023, 6, 15, 12, 34, 57));

    send(mk(2024, 2, 28, 23, 59, 59));
    pps_expect("feb", 1'b1, mk(2024, 2, 29, 0, 0, 0));
    send(mk(2023, 12, 31, 23, 59, 59));
    pps_expect("nye", 1'b1, mk(2024, 1, 1, 0, 0, 0));
    chk("lock3", locked, 1);

    repeat (880) @(negedge clk);
    chk("to_early", timeout, 0);
    chk("lock_early", locked, 1);
    repeat (150) @(negedge clk);
    chk("to_set", timeout, 1);
    chk("to_unlock", locked, 0);
    lock_m = 0;
    a = rand_valid();
    send(a);
    chk("to_clear", timeout, 0);
    pps_expect("after_to", 1'b1, plus1(a));

    send(mk(2023, 13, 1, 0, 0, 0));
    send(mk(2023, 4, 31, 0, 0, 0));
    err_m += 2;
    lock_m = 0;
    chk("err2", err_cnt, err_m);
    pps_expect("bad", 1'b0, '0);
    chk_tod("bad_hold", last);
    chk("bad_lock", locked, 0);

    a = mk(2023, 3, 10, 8, 0, 0);
    b = mk(2023, 3, 10, 9, 0, 0);
    send(a);
    @(negedge clk);
    pps = 1'b1;
    repeat (2) @(negedge clk);
    drive(b);
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    chk("race_ld", load, 1);
    chk_tod("race_old", mk(2023, 3, 10, 8, 0, 1));
    lock_m++;
    last = mk(2023, 3, 10, 8, 0, 1);
    pps = 1'b0;
    repeat (3) @(negedge clk);
    pps_expect("race_drop", 1'b0, '0);
    send(b);
    pps_expect("race_resend", 1'b1, mk(2023, 3, 10, 9, 0, 1));

    send(mk(2023, 6, 30, 23, 59, 60));
`ifdef THUNDER_LEAPSEC_EN
    pps_expect("leap", 1'b1, mk(2023, 7, 1, 0, 0, 0));
`else
    err_m++;
    lock_m = 0;
    chk("leap_err", err_cnt, err_m);
    pps_expect("leap", 1'b0, '0);
`endif

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        send(rand_bad());
        err_m = (err_m < 255) ? err_m + 1 : 255;
        lock_m = 0;
      end
      a = rand_valid();
      send(a);
      if ($urandom_range(0, 2) == 0) begin
        a = rand_valid();
        send(a);
      end
      if ($urandom_range(0, 3) == 0) begin
        send(rand_bad());
        err_m = (err_m < 255) ? err_m + 1 : 255;
      end
      pps_expect("rnd", 1'b1, plus1(a));
      chk("rnd_err", err_cnt, err_m);
    end

    send(rand_valid());
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("dis_lock", locked, 0);
    chk_tod("dis_tod", last);
    chk("dis_err", err_cnt, err_m);
    enable = 1'b1;
    lock_m = 0;
    repeat (2) @(negedge clk);
    pps_expect("dis_drop", 1'b0, '0);

    t = rand_valid();
    send(t);
    @(negedge clk);
    pps = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_pre", load, 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_load", load, 0);
    chk_tod("arst_tod", '0);
    chk("arst_lock", locked, 0);
    chk("arst_err", err_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
